// File: rtl/dma_ahb_pkg.sv
// Shared AHB3-Lite encodings and bridge FSM state type for the DMA
// configuration-space slave.
package dma_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/dma_ahb_strobe_gen.sv
// Combinational byte-lane strobe and legality decode from HSIZE and the
// low address bits.
module dma_ahb_strobe_gen #(
  parameter int unsigned DW = 32
) (
  input  logic [2:0]                    hsize_i,
  input  logic [$clog2(DW/8)-1:0]       addr_lo_i,
  output logic [DW/8-1:0]               strobe_o,
  output logic                          illegal_o
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);

  logic [NB-1:0] mask;
  logic          misaligned;

  // Mask of 2^hsize bytes shifted to the addressed lane; misaligned when any
  // address bit below hsize is set.
  always_comb begin
    mask       = '0;
    misaligned = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < (32'd1 << hsize_i)) mask[i] = 1'b1;
    end
    for (int unsigned i = 0; i < LW; i++) begin
      if ((i < 32'(hsize_i)) && addr_lo_i[i]) misaligned = 1'b1;
    end
    strobe_o  = mask << addr_lo_i;
    illegal_o = (32'(hsize_i) > LW) || misaligned;
  end

endmodule

// File: rtl/dma_slave_ahb3l_ws.sv
// AHB3-Lite to DMA register-file bridge with register-side wait states and
// two-cycle ERROR responses. Optional stall watchdog: DMA_SLAVE_TIMEOUT_EN.
module dma_slave_ahb3l_ws
  import dma_ahb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  input  logic              i_hsel,
  input  logic [1:0]        i_htrans,
  input  logic [2:0]        i_hsize,
  input  logic              i_hwrite,
  input  logic              i_hready,
  input  logic [AW-1:0]     i_haddr,
  input  logic [DW-1:0]     i_hwdata,
  output logic              o_hreadyout,
  output logic              o_hresp,
  output logic [DW-1:0]     o_hrdata,
  output logic [AW-1:0]     o_addr,
  output logic              o_read_en,
  output logic              o_write_en,
  output logic [DW/8-1:0]   o_byte_strobe,
  output logic [DW-1:0]     o_wdata,
  input  logic [DW-1:0]     i_rdata,
  input  logic              i_ready,
  input  logic              i_err
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [NB-1:0]   strb_q;
  logic            rd_q;
  logic            wr_q;
  logic            hready_q;
  logic            hresp_q;

  logic [NB-1:0]   strb_c;
  logic            illegal_c;
  logic            accept_c;
  logic            done_c;
  logic            unused_c;

  dma_ahb_strobe_gen #(.DW(DW)) u_strobe_gen (
    .hsize_i   (i_hsize),
    .addr_lo_i (i_haddr[LW-1:0]),
    .strobe_o  (strb_c),
    .illegal_o (illegal_c)
  );

  assign accept_c = i_hsel & i_hready & i_htrans[1];
  // States in which a new address phase may be taken on this edge.
  assign done_c   = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                    ((state_q == ST_ACCESS) && i_ready && !i_err);
  assign unused_c = i_htrans[0] ^ (^32'(TIMEOUT));

`ifdef DMA_SLAVE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q;
`endif

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      strb_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
`ifdef DMA_SLAVE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else if (done_c) begin
      if (accept_c && !illegal_c) begin
        state_q  <= ST_ACCESS;
        addr_q   <= i_haddr;
        strb_q   <= strb_c;
        rd_q     <= !i_hwrite;
        wr_q     <= i_hwrite;
        hready_q <= 1'b1;
        hresp_q  <= HRESP_OKAY;
`ifdef DMA_SLAVE_TIMEOUT_EN
        cnt_q    <= '0;
`endif
      end else begin
        // Illegal transfers never reach the register side.
        state_q  <= accept_c ? ST_ERR1 : ST_IDLE;
        addr_q   <= '0;
        strb_q   <= '0;
        rd_q     <= 1'b0;
        wr_q     <= 1'b0;
        hready_q <= !accept_c;
        hresp_q  <= accept_c ? HRESP_ERROR : HRESP_OKAY;
      end
    end else begin
      unique case (state_q)
        ST_ACCESS: begin
          if (i_ready) begin
            state_q  <= ST_ERR2;
            addr_q   <= '0;
            strb_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_ERROR;
`ifdef DMA_SLAVE_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q  <= ST_ERR1;
            addr_q   <= '0;
            strb_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            hready_q <= 1'b0;
            hresp_q  <= HRESP_ERROR;
          end else begin
            cnt_q    <= cnt_q + CW'(1);
`endif
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: ;
      endcase
    end
  end

  // Register-side completion is reflected on HREADYOUT in the same cycle.
  assign o_hreadyout   = (state_q == ST_ACCESS) ? (i_ready & !i_err) : hready_q;
  assign o_hresp       = hresp_q | ((state_q == ST_ACCESS) & i_ready & i_err);
  assign o_hrdata      = i_rdata;
  assign o_wdata       = i_hwdata;
  assign o_addr        = addr_q;
  assign o_byte_strobe = strb_q;
  assign o_read_en     = rd_q;
  assign o_write_en    = wr_q;

endmodule

// File: tb/tb_dma_slave_ahb3l_ws.sv
// Directed bench for dma_slave_ahb3l_ws: a DW=32 and a DW=64 instance
// (TIMEOUT=4), each with its bus HREADY looped back from HREADYOUT.
module tb_dma_slave_ahb3l_ws;
  import dma_ahb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // DW=32 instance signals
  logic        a_hsel, a_hwrite, a_ready, a_err;
  logic [1:0]  a_htrans;
  logic [2:0]  a_hsize;
  logic [31:0] a_haddr, a_hwdata, a_rdata;
  logic        a_hreadyout, a_hresp, a_rd, a_wr;
  logic [31:0] a_hrdata, a_addr, a_wdata;
  logic [3:0]  a_strb;

  // DW=64 instance signals
  logic        b_hsel, b_hwrite, b_ready, b_err;
  logic [1:0]  b_htrans;
  logic [2:0]  b_hsize;
  logic [31:0] b_haddr;
  logic [63:0] b_hwdata, b_rdata;
  logic        b_hreadyout, b_hresp, b_rd, b_wr;
  logic [63:0] b_hrdata, b_wdata;
  logic [31:0] b_addr;
  logic [7:0]  b_strb;

  dma_slave_ahb3l_ws #(.AW(32), .DW(32), .TIMEOUT(4)) u_a (
    .i_hclk(clk), .i_hreset(rst), .i_hsel(a_hsel), .i_htrans(a_htrans),
    .i_hsize(a_hsize), .i_hwrite(a_hwrite), .i_hready(a_hreadyout),
    .i_haddr(a_haddr), .i_hwdata(a_hwdata), .o_hreadyout(a_hreadyout),
    .o_hresp(a_hresp), .o_hrdata(a_hrdata), .o_addr(a_addr),
    .o_read_en(a_rd), .o_write_en(a_wr), .o_byte_strobe(a_strb),
    .o_wdata(a_wdata), .i_rdata(a_rdata), .i_ready(a_ready), .i_err(a_err)
  );

  dma_slave_ahb3l_ws #(.AW(32), .DW(64), .TIMEOUT(4)) u_b (
    .i_hclk(clk), .i_hreset(rst), .i_hsel(b_hsel), .i_htrans(b_htrans),
    .i_hsize(b_hsize), .i_hwrite(b_hwrite), .i_hready(b_hreadyout),
    .i_haddr(b_haddr), .i_hwdata(b_hwdata), .o_hreadyout(b_hreadyout),
    .o_hresp(b_hresp), .o_hrdata(b_hrdata), .o_addr(b_addr),
    .o_read_en(b_rd), .o_write_en(b_wr), .o_byte_strobe(b_strb),
    .o_wdata(b_wdata), .i_rdata(b_rdata), .i_ready(b_ready), .i_err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic a_req(input logic w, input logic [2:0] sz, input logic [31:0] ad);
    a_hsel = 1'b1; a_htrans = HTRANS_NONSEQ; a_hwrite = w; a_hsize = sz; a_haddr = ad;
  endtask

  task automatic a_clr;
    a_hsel = 1'b0; a_htrans = HTRANS_IDLE;
  endtask

  task automatic b_req(input logic w, input logic [2:0] sz, input logic [31:0] ad);
    b_hsel = 1'b1; b_htrans = HTRANS_NONSEQ; b_hwrite = w; b_hsize = sz; b_haddr = ad;
  endtask

  task automatic b_clr;
    b_hsel = 1'b0; b_htrans = HTRANS_IDLE;
  endtask

  initial begin
    int stall;
    rst = 1'b1;
    a_clr(); a_hwrite = 1'b0; a_hsize = HSIZE_WORD; a_haddr = '0;
    a_hwdata = 32'hCAFE_F00D; a_rdata = 32'hDEAD_BEEF; a_ready = 1'b1; a_err = 1'b0;
    b_clr(); b_hwrite = 1'b0; b_hsize = HSIZE_WORD; b_haddr = '0;
    b_hwdata = 64'h0123_4567_89AB_CDEF; b_rdata = 64'h1122_3344_5566_7788;
    b_ready = 1'b1; b_err = 1'b0;
    nx(); nx();
    rst = 1'b0;

    // Reset state
    mid();
    chk("rst_hreadyout", a_hreadyout, 1);
    chk("rst_hresp", a_hresp, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_wr", a_wr, 0);
    chk("rst_strb", a_strb, 0);
    chk("rst_b_hreadyout", b_hreadyout, 1);
    nx();

    // BUSY transfer: zero-wait OKAY, register side untouched
    a_hsel = 1'b1; a_htrans = HTRANS_BUSY; a_haddr = 32'h10;
    nx(); a_clr();
    mid();
    chk("busy_rd", a_rd, 0);
    chk("busy_hreadyout", a_hreadyout, 1);
    nx();

    // Word read 0x10, zero wait
    a_req(1'b0, HSIZE_WORD, 32'h10);
    nx(); a_clr();
    mid();
    chk("rd10_rd", a_rd, 1);
    chk("rd10_wr", a_wr, 0);
    chk("rd10_addr", a_addr, 32'h10);
    chk("rd10_strb", a_strb, 4'b1111);
    chk("rd10_hreadyout", a_hreadyout, 1);
    chk("rd10_hresp", a_hresp, 0);
    chk("rd10_hrdata", a_hrdata, 32'hDEAD_BEEF);
    nx();
    mid();
    chk("rd10_after_rd", a_rd, 0);
    chk("rd10_after_addr", a_addr, 0);
    chk("rd10_after_strb", a_strb, 0);
    nx();

    // Back-to-back: word read 0x0 then byte write 0x13 with no bubble
    a_req(1'b0, HSIZE_WORD, 32'h0);
    nx();
    a_req(1'b1, HSIZE_BYTE, 32'h13);
    mid();
    chk("b2b_rd", a_rd, 1);
    nx(); a_clr();
    mid();
    chk("b2b_wr", a_wr, 1);
    chk("b2b_rd_low", a_rd, 0);
    chk("b2b_addr", a_addr, 32'h13);
    chk("b2b_strb", a_strb, 4'b1000);
    chk("b2b_wdata", a_wdata, 32'hCAFE_F00D);
    nx();
    mid();
    chk("b2b_idle_wr", a_wr, 0);
    nx();

    // Misaligned word write to 0x02: ERR1 then ERR2
    a_req(1'b1, HSIZE_WORD, 32'h02);
    nx(); a_clr();
    mid();
    chk("mis_e1_hreadyout", a_hreadyout, 0);
    chk("mis_e1_hresp", a_hresp, 1);
    chk("mis_e1_wr", a_wr, 0);
    nx();
    mid();
    chk("mis_e2_hreadyout", a_hreadyout, 1);
    chk("mis_e2_hresp", a_hresp, 1);
    chk("mis_e2_wr", a_wr, 0);
    nx();
    mid();
    chk("mis_idle_hresp", a_hresp, 0);
    nx();

    // Register fault on write, then read accepted in ERR2
    a_err = 1'b1;
    a_req(1'b1, HSIZE_WORD, 32'h08);
    nx(); a_clr();
    mid();
    chk("ferr_wr", a_wr, 1);
    chk("ferr_e1_hreadyout", a_hreadyout, 0);
    chk("ferr_e1_hresp", a_hresp, 1);
    a_req(1'b0, HSIZE_WORD, 32'h04);
    nx();
    a_err = 1'b0;
    mid();
    chk("ferr_e2_hreadyout", a_hreadyout, 1);
    chk("ferr_e2_hresp", a_hresp, 1);
    chk("ferr_e2_wr", a_wr, 0);
    nx(); a_clr();
    mid();
    chk("ferr_rd", a_rd, 1);
    chk("ferr_rd_addr", a_addr, 32'h04);
    chk("ferr_rd_hresp", a_hresp, 0);
    chk("ferr_rd_hreadyout", a_hreadyout, 1);
    nx();
    mid();
    chk("ferr_idle_rd", a_rd, 0);
    nx();

    // DW=64 halfword write 0x06 with 3 wait states
    b_ready = 1'b0;
    b_req(1'b1, HSIZE_HALF, 32'h06);
    nx(); b_clr();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("hw_wait_wr", b_wr, 1);
      chk("hw_wait_strb", b_strb, 8'b1100_0000);
      chk("hw_wait_hreadyout", b_hreadyout, 0);
      nx();
    end
    b_ready = 1'b1;
    mid();
    chk("hw_done_wr", b_wr, 1);
    chk("hw_done_hreadyout", b_hreadyout, 1);
    chk("hw_done_hresp", b_hresp, 0);
    nx();
    mid();
    chk("hw_idle_wr", b_wr, 0);
    chk("hw_idle_strb", b_strb, 0);
    nx();

    // DW=64 doubleword read 0x08 with the register side stalled
    b_ready = 1'b0;
    b_req(1'b0, HSIZE_DWORD, 32'h08);
    nx(); b_clr();
    mid();
    chk("to_strb", b_strb, 8'hFF);
`ifdef DMA_SLAVE_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (i > 0) mid();
      chk("to_stall_rd", b_rd, 1);
      chk("to_stall_hreadyout", b_hreadyout, 0);
      nx();
    end
    mid();
    chk("to_e1_rd", b_rd, 0);
    chk("to_e1_hreadyout", b_hreadyout, 0);
    chk("to_e1_hresp", b_hresp, 1);
    nx();
    mid();
    chk("to_e2_hreadyout", b_hreadyout, 1);
    chk("to_e2_hresp", b_hresp, 1);
    nx();
    b_ready = 1'b1;
    mid();
    chk("to_idle_hresp", b_hresp, 0);
    nx();
`else
    stall = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) mid();
      if (b_rd && !b_hreadyout && !b_hresp) stall++;
      nx();
    end
    chk("stall_100", 64'(stall), 64'd100);
    b_ready = 1'b1;
    mid();
    chk("stall_release_hreadyout", b_hreadyout, 1);
    chk("stall_release_rd", b_rd, 1);
    nx();
    mid();
    chk("stall_idle_rd", b_rd, 0);
    nx();
`endif

    // Reset during a 2-wait read, then a normal read
    a_ready = 1'b0;
    a_req(1'b0, HSIZE_WORD, 32'h20);
    nx(); a_clr();
    mid();
    chk("rstx_w1_rd", a_rd, 1);
    chk("rstx_w1_hreadyout", a_hreadyout, 0);
    nx();
    mid();
    chk("rstx_w2_rd", a_rd, 1);
    nx();
    rst = 1'b1;
    nx();
    mid();
    chk("rstx_hreadyout", a_hreadyout, 1);
    chk("rstx_hresp", a_hresp, 0);
    chk("rstx_rd", a_rd, 0);
    chk("rstx_addr", a_addr, 0);
    chk("rstx_strb", a_strb, 0);
    rst = 1'b0;
    a_ready = 1'b1;
    a_req(1'b0, HSIZE_WORD, 32'h24);
    nx(); a_clr();
    mid();
    chk("rstx_post_rd", a_rd, 1);
    chk("rstx_post_addr", a_addr, 32'h24);
    chk("rstx_post_hreadyout", a_hreadyout, 1);
    nx();
    mid();
    chk("rstx_post_idle_rd", a_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
